// File: rtl/alu_share_sched_if.sv
// ---------------------------------------------------------------------------
// alu_share_sched_if
//   Bundles every non-clock/reset signal of the shared-ALU scheduler.
//   Signal groups:
//     req0_* / req1_* : valid/ready request channels (op, a, b) from two requesters
//     alu_*           : registered opcode/operands to the ALU, combinational result back
//     rsp_*           : valid/ready response channel tagged with the requester id
//   Modports:
//     slave  : the scheduler (alu_share_sched)
//     master : the surrounding environment (requesters, ALU, response consumer)
// ---------------------------------------------------------------------------
interface alu_share_sched_if #(
  parameter int W = 8
) ();

  logic         req0_valid;
  logic         req0_ready;
  logic [3:0]   req0_op;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;

  logic         req1_valid;
  logic         req1_ready;
  logic [3:0]   req1_op;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;

  logic [3:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_result;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_data;
  logic         rsp_illegal;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_data, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_data, rsp_illegal,
    output rsp_ready
  );

endinterface

// File: rtl/alu_share_sched.sv
// ---------------------------------------------------------------------------
// alu_share_sched
//   Shares one combinational ALU (ADD/SUB/SLL/SRA/SRL/GT/EQ/NEG) between two
//   requesters with round-robin arbitration and a single operation in flight.
//   IDLE accepts one request, EXEC captures the ALU result, RESP holds the
//   tagged response until the consumer takes it.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : alu_share_sched_if.slave (request, ALU and response channels)
//   Parameter W : operand/result width (must match the interface instance).
// ---------------------------------------------------------------------------
module alu_share_sched #(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic [3:0]   alu_op_q, alu_op_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_illegal_q, rsp_illegal_d;

  logic         grant0_s;
  logic         grant1_s;
  logic [3:0]   sel_op_s;
  logic [W-1:0] sel_a_s;
  logic [W-1:0] sel_b_s;

  // Round-robin winner selection; ready is forced low while reset is asserted.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        // Contention: the requester that did not win last time goes first.
        grant0_s = last_grant_q;
        grant1_s = ~last_grant_q;
      end else begin
        grant0_s = bus.req0_valid;
        grant1_s = bus.req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Mux the winning requester's payload.
  always_comb begin
    sel_op_s = bus.req0_op;
    sel_a_s  = bus.req0_a;
    sel_b_s  = bus.req0_b;
    if (grant1_s) begin
      sel_op_s = bus.req1_op;
      sel_a_s  = bus.req1_a;
      sel_b_s  = bus.req1_b;
    end else begin
      sel_op_s = bus.req0_op;
      sel_a_s  = bus.req0_a;
      sel_b_s  = bus.req0_b;
    end
  end

  // Next-state and registered-output computation for the IDLE/EXEC/RESP FSM.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    alu_op_d      = alu_op_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    rsp_illegal_d = rsp_illegal_q;
    case (state_q)
      IDLE: begin
        if (grant0_s || grant1_s) begin
          last_grant_d = grant1_s;
          rsp_id_d     = grant1_s;
          if (sel_op_s[3]) begin
            // Opcodes 0x8..0xF never reach the ALU: its inputs keep their
            // previous values and the response is produced directly.
            rsp_valid_d   = 1'b1;
            rsp_data_d    = {W{1'b0}};
            rsp_illegal_d = 1'b1;
            state_d       = RESP;
          end else begin
            alu_op_d = sel_op_s;
            alu_a_d  = sel_a_s;
            alu_b_d  = sel_b_s;
            state_d  = EXEC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_data_d    = bus.alu_result;
        rsp_illegal_d = 1'b0;
        rsp_valid_d   = 1'b1;
        state_d       = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      alu_op_q      <= 4'd0;
      alu_a_q       <= {W{1'b0}};
      alu_b_q       <= {W{1'b0}};
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_data_q    <= {W{1'b0}};
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      alu_op_q      <= alu_op_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign bus.req0_ready  = grant0_s;
  assign bus.req1_ready  = grant1_s;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_share_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_share_sched
//   Self-checking bench for alu_share_sched: a vector table plus hand-written
//   sequences for arbitration, stalls, illegal opcodes and reset. Expected
//   responses are queued at accept time and compared when the response
//   handshake happens.
// ---------------------------------------------------------------------------
module tb_alu_share_sched;

  logic clk;
  logic rst_n;

  alu_share_sched_if #(.W(8)) bus ();

  alu_share_sched #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU attached to the scheduler's registered operands.
  logic [7:0] alu_res;
  always_comb begin
    alu_res = 8'h00;
    case (bus.alu_op)
      4'd0:    alu_res = bus.alu_a + bus.alu_b;
      4'd1:    alu_res = bus.alu_a - bus.alu_b;
      4'd2:    alu_res = bus.alu_a << bus.alu_b;
      4'd3:    alu_res = $signed(bus.alu_a) >>> bus.alu_b;
      4'd4:    alu_res = bus.alu_a >> bus.alu_b;
      4'd5:    alu_res = (bus.alu_a > bus.alu_b) ? 8'h01 : 8'h00;
      4'd6:    alu_res = (bus.alu_a == bus.alu_b) ? 8'h01 : 8'h00;
      4'd7:    alu_res = 8'h00 - bus.alu_a;
      default: alu_res = 8'h00;
    endcase
  end
  assign bus.alu_result = alu_res;

  typedef struct {
    bit         id;
    logic [7:0] data;
    bit         ill;
    int         acc;
    int         lat;
  } exp_t;

  typedef struct {
    bit         id;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    bit         ill;
  } vec_t;

  exp_t sb[$];
  bit   grant_log[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   hs_cyc = 0;
  bit   first_seen = 1'b0;

  // Cycle counter used for latency and throughput checks.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Response monitor: latency on the first valid cycle, payload on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      first_seen = 1'b0;
    end else if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(bus.rsp_valid), 32'(0));
      end else begin
        if (!first_seen) begin
          chk("rsp_latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
          first_seen = 1'b1;
        end
        if (bus.rsp_ready) begin
          e = sb.pop_front();
          chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
          chk("rsp_illegal", 32'(bus.rsp_illegal), 32'(e.ill));
          first_seen = 1'b0;
          hs_cyc = cyc;
        end
      end
    end
  end

  // Present one request and wait (bounded) for it to be accepted.
  task automatic issue(input bit id, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp, input bit ill,
                       output int acc);
    bit done;
    done = 1'b0;
    acc  = -1;
    if (id == 1'b0) begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if ((id == 1'b0 && bus.req0_ready) || (id == 1'b1 && bus.req1_ready)) begin
        sb.push_back('{id, exp, ill, cyc, (ill ? 1 : 2)});
        grant_log.push_back(id);
        acc  = cyc;
        done = 1'b1;
      end
    end
    chk("accept", 32'(done), 32'(1));
    @(posedge clk);
    #1;
    if (id == 1'b0) bus.req0_valid = 1'b0;
    else            bus.req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt[8];
  int   acc_a, acc_b, acc_prev;
  bit   seen;

  // Main stimulus sequence.
  initial begin
    vt[0] = '{1'b0, 4'd0, 8'h7F, 8'h01, 8'h80, 1'b0};  // ADD
    vt[1] = '{1'b1, 4'd1, 8'h05, 8'h07, 8'hFE, 1'b0};  // SUB
    vt[2] = '{1'b0, 4'd2, 8'h03, 8'h02, 8'h0C, 1'b0};  // SLL
    vt[3] = '{1'b1, 4'd4, 8'hF0, 8'h04, 8'h0F, 1'b0};  // SRL
    vt[4] = '{1'b0, 4'd5, 8'h09, 8'h03, 8'h01, 1'b0};  // GT
    vt[5] = '{1'b1, 4'd6, 8'h5A, 8'h5A, 8'h01, 1'b0};  // EQ
    vt[6] = '{1'b0, 4'd7, 8'h01, 8'h00, 8'hFF, 1'b0};  // NEG
    vt[7] = '{1'b1, 4'hF, 8'h11, 8'h22, 8'h00, 1'b1};  // illegal

    bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
    bus.req1_valid = 1'b1; bus.req1_op = 4'd0; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
    bus.rsp_ready  = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state: registered outputs zero, ready gated low despite valids.
    chk("rst_alu_op", 32'(bus.alu_op), 32'(0));
    chk("rst_alu_a", 32'(bus.alu_a), 32'(0));
    chk("rst_alu_b", 32'(bus.alu_b), 32'(0));
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'(0));
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'(0));
    chk("rst_rsp_illegal", 32'(bus.rsp_illegal), 32'(0));
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'(0));
    chk("rst_req1_ready", 32'(bus.req1_ready), 32'(0));
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention straight after reset: grants alternate 0,1,0,1.
    fork
      begin
        issue(1'b0, 4'd0, 8'h7F, 8'h01, 8'h80, 1'b0, acc_a);
        issue(1'b0, 4'd2, 8'h01, 8'h07, 8'h80, 1'b0, acc_a);
      end
      begin
        issue(1'b1, 4'd1, 8'h05, 8'h07, 8'hFE, 1'b0, acc_b);
        issue(1'b1, 4'd4, 8'h80, 8'h07, 8'h01, 1'b0, acc_b);
      end
    join
    wait_drain();
    chk("grant_cnt", 32'(grant_log.size()), 32'(4));
    if (grant_log.size() == 4) begin
      chk("grant_0", 32'(grant_log[0]), 32'(0));
      chk("grant_1", 32'(grant_log[1]), 32'(1));
      chk("grant_2", 32'(grant_log[2]), 32'(0));
      chk("grant_3", 32'(grant_log[3]), 32'(1));
    end

    // Table of single requests covering every opcode class.
    for (int i = 0; i < 8; i++) begin
      issue(vt[i].id, vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].ill, acc_a);
    end
    wait_drain();

    // Illegal opcode leaves the ALU inputs at the previous legal operation.
    issue(1'b0, 4'd0, 8'h12, 8'h34, 8'h46, 1'b0, acc_a);
    issue(1'b1, 4'hA, 8'h55, 8'h66, 8'h00, 1'b1, acc_a);
    wait_drain();
    chk("ill_alu_op", 32'(bus.alu_op), 32'(0));
    chk("ill_alu_a", 32'(bus.alu_a), 32'(8'h12));
    chk("ill_alu_b", 32'(bus.alu_b), 32'(8'h34));

    // Response stall: payload stable, no accepts, next accept one cycle after handshake.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 4'd0, 8'h10, 8'h20, 8'h30, 1'b0, acc_a);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = bus.rsp_valid;
    end
    chk("stall_rsp_seen", 32'(seen), 32'(1));
    fork
      issue(1'b1, 4'd1, 8'h09, 8'h02, 8'h07, 1'b0, acc_b);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_valid", 32'(bus.rsp_valid), 32'(1));
          chk("stall_id", 32'(bus.rsp_id), 32'(0));
          chk("stall_data", 32'(bus.rsp_data), 32'(8'h30));
          chk("stall_illegal", 32'(bus.rsp_illegal), 32'(0));
          chk("stall_req0_ready", 32'(bus.req0_ready), 32'(0));
          chk("stall_req1_ready", 32'(bus.req1_ready), 32'(0));
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
      end
    join
    chk("stall_next_accept", 32'(acc_b - hs_cyc), 32'(1));
    wait_drain();

    // Reset while EXEC: everything clears at once and the op is dropped.
    issue(1'b0, 4'd0, 8'h01, 8'h01, 8'h02, 1'b0, acc_a);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_op", 32'(bus.alu_op), 32'(0));
    chk("mid_rst_alu_a", 32'(bus.alu_a), 32'(0));
    chk("mid_rst_alu_b", 32'(bus.alu_b), 32'(0));
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("mid_rst_rsp_id", 32'(bus.rsp_id), 32'(0));
    chk("mid_rst_rsp_data", 32'(bus.rsp_data), 32'(0));
    chk("mid_rst_rsp_illegal", 32'(bus.rsp_illegal), 32'(0));
    chk("mid_rst_req0_ready", 32'(bus.req0_ready), 32'(0));
    chk("mid_rst_req1_ready", 32'(bus.req1_ready), 32'(0));
    sb.delete();
    grant_log.delete();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fork
      issue(1'b1, 4'd6, 8'h07, 8'h07, 8'h01, 1'b0, acc_b);
      issue(1'b0, 4'd5, 8'h03, 8'h09, 8'h00, 1'b0, acc_a);
    join
    wait_drain();
    chk("post_rst_grant_cnt", 32'(grant_log.size()), 32'(2));
    if (grant_log.size() == 2) begin
      chk("post_rst_first_grant", 32'(grant_log[0]), 32'(0));
    end

    // Only requester 1 streams SRA: back-to-back grants every 3 cycles.
    grant_log.delete();
    issue(1'b1, 4'd3, 8'h80, 8'h01, 8'hC0, 1'b0, acc_prev);
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 4'd3, 8'h80, 8'h01, 8'hC0, 1'b0, acc_b);
      chk("stream_gap", 32'(acc_b - acc_prev), 32'(3));
      acc_prev = acc_b;
    end
    chk("stream_grants", 32'(grant_log.size()), 32'(4));
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      chk("stream_grant_id", 32'(grant_log[i]), 32'(1));
    end
    wait_drain();

    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
